// File: rtl/fluxo_dados_param_if.sv
// Control/status bundle between the memory-game FSM (master) and the datapath (slave).
interface fluxo_dados_param_if #(
   parameter int W     = 4,
   parameter int AW    = 4,
   parameter int NBANK = 2
);
   localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;

   logic          zeraE, contaE, zeraS, contaS, zeraR, registraR, gravaM;
   logic          espera, ledsOn, ledsOff, exibe, joga;
   logic [W-1:0]  chaves;
   logic          coringa;
   logic [BW-1:0] banco;
   logic [AW-1:0] limite;

   logic          bancoChange, limiteChange;
   logic          jogadaIgualMemoria, enderecoIgualSequencia, fimS, jogada_valida;
   logic          tem_jogada, tem_coringa;
   logic          fimLedsOn, fimLedsOff, timeout;
   logic [W-1:0]  leds;
   logic [AW-1:0] db_endereco, db_sequencia;
   logic [W-1:0]  db_memoria, db_jogada;

   modport master (
      output zeraE, contaE, zeraS, contaS, zeraR, registraR, gravaM,
             espera, ledsOn, ledsOff, exibe, joga, chaves, coringa, banco, limite,
      input  bancoChange, limiteChange, jogadaIgualMemoria, enderecoIgualSequencia,
             fimS, jogada_valida, tem_jogada, tem_coringa, fimLedsOn, fimLedsOff,
             timeout, leds, db_endereco, db_sequencia, db_memoria, db_jogada
   );

   modport slave (
      input  zeraE, contaE, zeraS, contaS, zeraR, registraR, gravaM,
             espera, ledsOn, ledsOff, exibe, joga, chaves, coringa, banco, limite,
      output bancoChange, limiteChange, jogadaIgualMemoria, enderecoIgualSequencia,
             fimS, jogada_valida, tem_jogada, tem_coringa, fimLedsOn, fimLedsOff,
             timeout, leds, db_endereco, db_sequencia, db_memoria, db_jogada
   );
endinterface

// File: rtl/fluxo_dados_param.sv
// Memory-game datapath: counters, banked writable sequence RAM, jogada register,
// LED/timeout timers and input edge/change detectors, all steered by the game FSM.
module fluxo_dados_param #(
   parameter int W         = 4,
   parameter int AW        = 4,
   parameter int NBANK     = 2,
   parameter int T_ON      = 50,
   parameter int T_OFF     = 50,
   parameter int T_TIMEOUT = 5000
) (
   input logic                 clock,
   input logic                 reset,
   fluxo_dados_param_if.slave  bus
);
   localparam int BW    = (NBANK > 1) ? $clog2(NBANK) : 1;
   localparam int DEPTH = 1 << AW;
   localparam int ONW   = $clog2(T_ON + 1);
   localparam int OFFW  = $clog2(T_OFF + 1);
   localparam int TOW   = $clog2(T_TIMEOUT + 1);
   localparam logic [ONW-1:0]  ON_MAX  = ONW'(T_ON - 1);
   localparam logic [OFFW-1:0] OFF_MAX = OFFW'(T_OFF - 1);
   localparam logic [TOW-1:0]  TO_MAX  = TOW'(T_TIMEOUT - 1);

   logic [AW-1:0]   r_endereco, r_sequencia;
   logic [W-1:0]    r_jogada, r_mem_q, r_led;
   logic [ONW-1:0]  r_cnt_on;
   logic [OFFW-1:0] r_cnt_off;
   logic [TOW-1:0]  r_cnt_to;
   logic            r_timeout, r_tecla_ant, r_coringa_ant;
   logic [BW-1:0]   r_banco_ant;
   logic [AW-1:0]   r_limite_ant;
   logic [W-1:0]    r_mem [0:NBANK*DEPTH-1];

   logic            w_tecla, w_tem_jogada, w_tem_coringa, w_clr_to;
   logic [BW+AW-1:0] w_idx;

   assign w_tecla       = |bus.chaves;
   assign w_tem_jogada  = w_tecla & ~r_tecla_ant;
   assign w_tem_coringa = bus.coringa & ~r_coringa_ant;
   assign w_clr_to      = bus.zeraE | w_tem_jogada | w_tem_coringa;
   assign w_idx         = {bus.banco, r_endereco};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_endereco    <= '0;
         r_sequencia   <= '0;
         r_jogada      <= '0;
         r_mem_q       <= '0;
         r_led         <= '0;
         r_cnt_on      <= '0;
         r_cnt_off     <= '0;
         r_cnt_to      <= '0;
         r_timeout     <= 1'b0;
         r_tecla_ant   <= 1'b0;
         r_coringa_ant <= 1'b0;
      end else begin
         if (bus.zeraE)       r_endereco <= '0;
         else if (bus.contaE) r_endereco <= r_endereco + 1'b1;

         if (bus.zeraS)       r_sequencia <= '0;
         else if (bus.contaS) r_sequencia <= r_sequencia + 1'b1;

         if (bus.zeraR)          r_jogada <= '0;
         else if (bus.registraR) r_jogada <= bus.chaves;

         // Synchronous read; a same-cycle write lands after this sample (old data).
         r_mem_q <= r_mem[w_idx];

         if (bus.zeraR || bus.ledsOff || bus.espera) r_led <= '0;
         else if (bus.ledsOn)                        r_led <= r_mem_q;

         if (bus.ledsOff || bus.zeraS)           r_cnt_on <= '0;
         else if (bus.ledsOn && r_cnt_on != ON_MAX) r_cnt_on <= r_cnt_on + 1'b1;

         if (bus.ledsOn || bus.zeraS)              r_cnt_off <= '0;
         else if (bus.ledsOff && r_cnt_off != OFF_MAX) r_cnt_off <= r_cnt_off + 1'b1;

         if (w_clr_to)                               r_cnt_to <= '0;
         else if (bus.espera && r_cnt_to != TO_MAX)  r_cnt_to <= r_cnt_to + 1'b1;

         if (bus.zeraR)                                r_timeout <= 1'b0;
         else if (bus.espera && r_cnt_to == TO_MAX)    r_timeout <= 1'b1;

         r_tecla_ant   <= w_tecla;
         r_coringa_ant <= bus.coringa;
      end
   end

   // RAM array and change-detector history carry no reset; the detectors keep
   // tracking their inputs while reset is held so release produces no pulse.
   always_ff @(posedge clock) begin
      if (bus.gravaM) r_mem[w_idx] <= r_jogada;
      r_banco_ant  <= bus.banco;
      r_limite_ant <= bus.limite;
   end

   assign bus.bancoChange            = (bus.banco != r_banco_ant);
   assign bus.limiteChange           = (bus.limite != r_limite_ant);
   assign bus.jogadaIgualMemoria     = (r_mem_q == r_jogada);
   assign bus.enderecoIgualSequencia = (r_endereco == r_sequencia);
   assign bus.fimS                   = (r_sequencia == bus.limite);
   assign bus.jogada_valida          = w_tecla && ((bus.chaves & (bus.chaves - 1'b1)) == '0);
   assign bus.tem_jogada             = w_tem_jogada;
   assign bus.tem_coringa            = w_tem_coringa;
   assign bus.fimLedsOn              = (r_cnt_on == ON_MAX);
   assign bus.fimLedsOff             = (r_cnt_off == OFF_MAX);
   assign bus.timeout                = r_timeout;
   assign bus.leds                   = bus.exibe ? r_led : (bus.joga ? bus.chaves : '1);
   assign bus.db_endereco            = r_endereco;
   assign bus.db_sequencia           = r_sequencia;
   assign bus.db_memoria             = r_mem_q;
   assign bus.db_jogada              = r_jogada;
endmodule

// File: tb/tb_fluxo_dados_param.sv
// Directed bench for fluxo_dados_param with hand-computed expectations.
module tb_fluxo_dados_param;
   localparam int W = 4, AW = 4, NBANK = 2;
   localparam int T_ON = 6, T_OFF = 4, T_TIMEOUT = 30;

   logic clock = 1'b0;
   logic reset;
   int   n_chk = 0, n_pass = 0, n_fail = 0;

   fluxo_dados_param_if #(.W(W), .AW(AW), .NBANK(NBANK)) bus ();

   fluxo_dados_param #(.W(W), .AW(AW), .NBANK(NBANK), .T_ON(T_ON), .T_OFF(T_OFF),
                       .T_TIMEOUT(T_TIMEOUT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      {bus.zeraE, bus.contaE, bus.zeraS, bus.contaS, bus.zeraR, bus.registraR, bus.gravaM} = '0;
      {bus.espera, bus.ledsOn, bus.ledsOff, bus.exibe, bus.joga, bus.coringa} = '0;
      bus.chaves = '0;
      bus.banco  = 1'b1;
      bus.limite = 4'd3;
      repeat (3) tick();
      reset = 1'b1;
      #1;
      check("rst_bancoChange", bus.bancoChange, 0);
      check("rst_limiteChange", bus.limiteChange, 0);
      check("rst_leds", bus.leds, 4'hF);
      check("rst_endereco", bus.db_endereco, 0);
      check("rst_sequencia", bus.db_sequencia, 0);
      check("rst_timeout", bus.timeout, 0);
      check("rst_tem_jogada", bus.tem_jogada, 0);
      tick();
      check("rel_bancoChange", bus.bancoChange, 0);

      // record 1,2,4,8 into bank 1, addresses 0..3
      for (int i = 0; i < 4; i++) begin
         bus.chaves = 4'(1 << i); bus.registraR = 1'b1; tick();
         bus.registraR = 1'b0; bus.chaves = '0; bus.gravaM = 1'b1; tick();
         bus.gravaM = 1'b0; bus.contaE = 1'b1; tick();
         bus.contaE = 1'b0;
      end
      check("db_jogada", bus.db_jogada, 4'h8);

      bus.zeraE = 1'b1; tick(); bus.zeraE = 1'b0;
      bus.contaE = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("replay_mem", bus.db_memoria, 32'(1 << i));
         check("replay_igual", bus.jogadaIgualMemoria, (i == 3) ? 1 : 0);
      end
      bus.contaE = 1'b0;

      bus.banco = 1'b0; #1;
      check("bancoChange_pulse", bus.bancoChange, 1);
      tick();
      check("bancoChange_end", bus.bancoChange, 0);
      bus.zeraE = 1'b1; tick(); bus.zeraE = 1'b0;
      bus.chaves = 4'h6; bus.registraR = 1'b1; tick();
      bus.registraR = 1'b0; bus.chaves = '0;
      bus.gravaM = 1'b1; tick(); bus.gravaM = 1'b0;
      tick();
      check("bank0_addr0", bus.db_memoria, 4'h6);
      bus.banco = 1'b1; tick();
      check("bank1_untouched", bus.db_memoria, 4'h1);
      bus.gravaM = 1'b1; tick(); bus.gravaM = 1'b0;
      check("rdw_old", bus.db_memoria, 4'h1);
      tick();
      check("rdw_new", bus.db_memoria, 4'h6);

      // sequence counter against limite
      bus.zeraS = 1'b1; tick(); bus.zeraS = 1'b0;
      check("endIgualSeq", bus.enderecoIgualSequencia, 1);
      bus.contaS = 1'b1;
      for (int s = 0; s < 5; s++) begin
         check("seq_val", bus.db_sequencia, s);
         check("fimS", bus.fimS, (s == 3) ? 1 : 0);
         tick();
      end
      bus.contaS = 1'b0;
      check("endIgualSeq_ne", bus.enderecoIgualSequencia, 0);

      bus.zeraE = 1'b1; tick(); bus.zeraE = 1'b0;
      bus.contaE = 1'b1;
      repeat (15) tick();
      check("end_15", bus.db_endereco, 15);
      tick();
      check("end_wrap", bus.db_endereco, 0);
      bus.contaE = 1'b0;

      // LED display of bank1[2] = 4
      bus.zeraE = 1'b1; tick(); bus.zeraE = 1'b0;
      bus.contaE = 1'b1; tick(); tick(); bus.contaE = 1'b0;
      tick();
      bus.exibe = 1'b1; bus.ledsOn = 1'b1;
      for (int c = 1; c <= T_ON; c++) begin
         #1;
         check("fimLedsOn", bus.fimLedsOn, (c == T_ON) ? 1 : 0);
         if (c < T_ON) tick();
      end
      check("leds_on", bus.leds, 4'h4);
      tick();
      check("fimLedsOn_hold", bus.fimLedsOn, 1);
      bus.ledsOn = 1'b0; bus.ledsOff = 1'b1; tick();
      check("leds_off", bus.leds, 0);
      check("fimLedsOn_clr", bus.fimLedsOn, 0);
      check("fimLedsOff_early", bus.fimLedsOff, 0);
      repeat (T_OFF - 2) tick();
      check("fimLedsOff", bus.fimLedsOff, 1);
      bus.ledsOff = 1'b0; bus.exibe = 1'b0;

      bus.joga = 1'b1; bus.chaves = 4'h2; #1;
      check("leds_joga", bus.leds, 4'h2);
      bus.joga = 1'b0; bus.chaves = '0; tick();

      // timeout
      bus.zeraR = 1'b1; tick(); bus.zeraR = 1'b0;
      bus.zeraE = 1'b1; tick(); bus.zeraE = 1'b0;
      bus.espera = 1'b1;
      repeat (T_TIMEOUT - 1) tick();
      check("timeout_early", bus.timeout, 0);
      tick();
      check("timeout_set", bus.timeout, 1);
      repeat (3) tick();
      bus.espera = 1'b0; tick();
      check("timeout_sticky", bus.timeout, 1);
      bus.zeraR = 1'b1; tick(); bus.zeraR = 1'b0;
      check("timeout_clr", bus.timeout, 0);

      bus.zeraE = 1'b1; tick(); bus.zeraE = 1'b0;
      bus.espera = 1'b1;
      repeat (T_TIMEOUT - 10) tick();
      bus.chaves = 4'h1; #1;
      check("press_pulse", bus.tem_jogada, 1);
      tick();
      check("press_pulse_end", bus.tem_jogada, 0);
      repeat (T_TIMEOUT - 2) tick();
      check("timeout_restart", bus.timeout, 0);
      bus.espera = 1'b0; bus.chaves = '0; tick();

      // edge detectors and key validity
      bus.chaves = 4'h6; #1;
      check("tem_jogada_0110", bus.tem_jogada, 1);
      check("valida_0110", bus.jogada_valida, 0);
      tick();
      check("tem_jogada_single", bus.tem_jogada, 0);
      bus.chaves = 4'h4; #1;
      check("valida_0100", bus.jogada_valida, 1);
      check("tem_jogada_held", bus.tem_jogada, 0);
      bus.chaves = '0; bus.coringa = 1'b1; #1;
      check("tem_coringa", bus.tem_coringa, 1);
      tick();
      check("tem_coringa_end", bus.tem_coringa, 0);
      bus.coringa = 1'b0;

      bus.limite = 4'd5; #1;
      check("limiteChange_pulse", bus.limiteChange, 1);
      tick();
      check("limiteChange_end", bus.limiteChange, 0);
      tick();
      check("limiteChange_quiet", bus.limiteChange, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
